// File: rtl/xevious_boot_ctrl.sv
// Boot / download sequencer for the Xevious core.
//
// Accepts the HPS ioctl download stream, forwards ROM bytes to the core's
// dn_* write port, latches the two DIP switch bytes (stored active-low), and
// owns the core reset. The core is held in reset while no complete ROM set
// is present and for HOLD_CYCLES cycles after a load or a reset request. The
// hiscore engine is enabled only while the core is running.
//
// Ports:
//   clk_sys, reset                 system clock, synchronous active-high reset
//   ioctl_download/wr/index/addr/dout   HPS download stream
//   status_reset, user_button      level reset requests
//   service_sw                     service switch; its rising edge requests a reset
//   dn_wr/dn_addr/dn_data          ROM write port to the core (1-cycle latency)
//   dsw_a, dsw_b                   DIP banks, active-low
//   core_reset                     reset to the core
//   rom_ok, rom_err                result of the last ROM download
//   hs_enable                      hiscore engine may run
//   led                            high while a ROM is loading
module xevious_boot_ctrl #(
    parameter logic [7:0]  ROM_INDEX   = 8'd0,
    parameter logic [7:0]  DIP_INDEX   = 8'd254,
    parameter logic [16:0] ROM_SIZE    = 17'd69632,
    parameter int          HOLD_CYCLES = 1024
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        status_reset,
    input  logic        user_button,
    input  logic        service_sw,
    output logic        dn_wr,
    output logic [16:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic [7:0]  dsw_a,
    output logic [7:0]  dsw_b,
    output logic        core_reset,
    output logic        rom_ok,
    output logic        rom_err,
    output logic        hs_enable,
    output logic        led
);

    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_LOAD,
        ST_HOLD,
        ST_RUN
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic [16:0]   count_reg;
    logic [16:0]   count_next;
    logic [HW-1:0] hold_reg;
    logic          svc_prev_reg;

    logic rom_start;
    logic svc_rise;
    logic rreq;
    logic rom_wr;
    logic rom_full;
    logic dip_wr;

    assign rom_start = ioctl_download && (ioctl_index == ROM_INDEX);
    assign svc_rise  = service_sw && !svc_prev_reg;
    assign rreq      = status_reset || user_button || svc_rise;

    // Only in-range ROM bytes received while loading are forwarded and counted.
    assign rom_wr = (state_reg == ST_LOAD) && ioctl_wr && (ioctl_index == ROM_INDEX)
                    && (ioctl_addr < {8'd0, ROM_SIZE});

    // Saturating byte count including this cycle's byte, so a byte arriving
    // in the same cycle the download ends still counts toward the length check.
    assign count_next = (rom_wr && (count_reg != ROM_SIZE)) ? count_reg + 17'd1 : count_reg;
    assign rom_full   = (count_next >= ROM_SIZE);

    assign dip_wr = ioctl_wr && (ioctl_index == DIP_INDEX) && (ioctl_addr[24:1] == 24'd0);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_BOOT: begin
                if (rom_start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (!ioctl_download) state_next = rom_full ? ST_HOLD : ST_BOOT;
            end
            ST_HOLD: begin
                // A new download wins over a reset request in the same cycle.
                if (rom_start)                     state_next = ST_LOAD;
                else if (!rreq && hold_reg == '0)  state_next = ST_RUN;
            end
            ST_RUN: begin
                if (rom_start)  state_next = ST_LOAD;
                else if (rreq)  state_next = ST_HOLD;
            end
            default: state_next = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg    <= ST_BOOT;
            count_reg    <= '0;
            hold_reg     <= '0;
            svc_prev_reg <= service_sw;
            dn_wr        <= 1'b0;
            dn_addr      <= '0;
            dn_data      <= '0;
            dsw_a        <= 8'hFF;
            dsw_b        <= 8'hFF;
            core_reset   <= 1'b1;
            rom_ok       <= 1'b0;
            rom_err      <= 1'b0;
            hs_enable    <= 1'b0;
            led          <= 1'b0;
        end else begin
            state_reg    <= state_next;
            svc_prev_reg <= service_sw;

            // Outputs follow the state being entered so they change together.
            core_reset <= (state_next != ST_RUN);
            hs_enable  <= (state_next == ST_RUN);
            led        <= (state_next == ST_LOAD);

            // Byte counter: cleared on LOAD entry, accumulates while loading.
            if (state_next == ST_LOAD && state_reg != ST_LOAD) begin
                count_reg <= '0;
                rom_ok    <= 1'b0;
            end else if (state_reg == ST_LOAD) begin
                count_reg <= count_next;
            end

            if (state_reg == ST_LOAD && !ioctl_download) begin
                rom_ok  <= rom_full;
                rom_err <= !rom_full;
            end

            // Hold counter: reloaded on entry and on any request while holding.
            if (state_next == ST_HOLD && (state_reg != ST_HOLD || rreq)) begin
                hold_reg <= HOLD_LOAD;
            end else if (state_reg == ST_HOLD) begin
                hold_reg <= hold_reg - 1'b1;
            end

            dn_wr <= rom_wr;
            if (rom_wr) begin
                dn_addr <= ioctl_addr[16:0];
                dn_data <= ioctl_dout;
            end

            if (dip_wr) begin
                if (ioctl_addr[0]) dsw_b <= ~ioctl_dout;
                else               dsw_a <= ~ioctl_dout;
            end
        end
    end

endmodule

// File: tb/tb_xevious_boot_ctrl.sv
// Testbench for xevious_boot_ctrl: randomized download / reset-request
// stimulus, a behavioural model checked every cycle, and literal checks on
// the key scenario outcomes.
module tb_xevious_boot_ctrl;

    localparam int ROM_SZ = 3000;
    localparam int HOLD   = 1024;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        status_reset;
    logic        user_button;
    logic        service_sw;
    logic        dn_wr;
    logic [16:0] dn_addr;
    logic [7:0]  dn_data;
    logic [7:0]  dsw_a;
    logic [7:0]  dsw_b;
    logic        core_reset;
    logic        rom_ok;
    logic        rom_err;
    logic        hs_enable;
    logic        led;

    always #5 clk_sys = ~clk_sys;

    xevious_boot_ctrl #(
        .ROM_INDEX  (8'd0),
        .DIP_INDEX  (8'd254),
        .ROM_SIZE   (17'(ROM_SZ)),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_index   (ioctl_index),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .status_reset  (status_reset),
        .user_button   (user_button),
        .service_sw    (service_sw),
        .dn_wr         (dn_wr),
        .dn_addr       (dn_addr),
        .dn_data       (dn_data),
        .dsw_a         (dsw_a),
        .dsw_b         (dsw_b),
        .core_reset    (core_reset),
        .rom_ok        (rom_ok),
        .rom_err       (rom_err),
        .hs_enable     (hs_enable),
        .led           (led)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The core is either loading, holding for m_hold_left more cycles,
    // running, or idle waiting for a ROM (none of the three).
    bit          m_valid = 0;
    bit          m_loading, m_running, m_svc_prev;
    int          m_hold_left, m_count;
    bit          e_dn_wr, e_rom_ok, e_rom_err;
    logic [16:0] e_dn_addr;
    logic [7:0]  e_dn_data, e_dsw_a, e_dsw_b;
    bit          t_start, t_rise, t_rreq, t_byte;

    always @(posedge clk_sys) begin
        if (reset) begin
            m_valid     = 1;
            m_loading   = 0;
            m_running   = 0;
            m_hold_left = 0;
            m_count     = 0;
            m_svc_prev  = service_sw;
            e_dn_wr     = 0;
            e_dn_addr   = '0;
            e_dn_data   = '0;
            e_dsw_a     = 8'hFF;
            e_dsw_b     = 8'hFF;
            e_rom_ok    = 0;
            e_rom_err   = 0;
        end else if (m_valid) begin
            t_start    = ioctl_download && ioctl_index == 8'd0;
            t_rise     = service_sw && !m_svc_prev;
            m_svc_prev = service_sw;
            t_rreq     = status_reset || user_button || t_rise;
            t_byte     = m_loading && ioctl_wr && ioctl_index == 8'd0 && ioctl_addr < 25'(ROM_SZ);
            e_dn_wr    = t_byte;
            if (t_byte) begin
                e_dn_addr = ioctl_addr[16:0];
                e_dn_data = ioctl_dout;
            end
            if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < 25'd2) begin
                if (ioctl_addr[0]) e_dsw_b = ~ioctl_dout;
                else               e_dsw_a = ~ioctl_dout;
            end
            if (m_loading) begin
                if (t_byte && m_count < ROM_SZ) m_count++;
                if (!ioctl_download) begin
                    m_loading = 0;
                    if (m_count >= ROM_SZ) begin
                        e_rom_ok    = 1;
                        e_rom_err   = 0;
                        m_hold_left = HOLD;
                    end else begin
                        e_rom_ok  = 0;
                        e_rom_err = 1;
                    end
                end
            end else if (t_start) begin
                m_loading   = 1;
                m_running   = 0;
                m_hold_left = 0;
                m_count     = 0;
                e_rom_ok    = 0;
            end else if (m_running || m_hold_left > 0) begin
                if (t_rreq) begin
                    m_running   = 0;
                    m_hold_left = HOLD;
                end else if (m_hold_left > 0) begin
                    m_hold_left--;
                    if (m_hold_left == 0) m_running = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk_sys) begin
        if (m_valid) begin
            chk("dn_wr", 32'(dn_wr), 32'(e_dn_wr));
            if (e_dn_wr) begin
                chk("dn_addr", 32'(dn_addr), 32'(e_dn_addr));
                chk("dn_data", 32'(dn_data), 32'(e_dn_data));
            end
            chk("dsw_a", 32'(dsw_a), 32'(e_dsw_a));
            chk("dsw_b", 32'(dsw_b), 32'(e_dsw_b));
            chk("core_reset", 32'(core_reset), 32'(!m_running));
            chk("hs_enable", 32'(hs_enable), 32'(m_running));
            chk("led", 32'(led), 32'(m_loading));
            chk("rom_ok", 32'(rom_ok), 32'(e_rom_ok));
            chk("rom_err", 32'(rom_err), 32'(e_rom_err));
        end
    end

    // Running totals used for the literal length checks.
    int hold_total = 0;  // cycles with core_reset high and not loading
    int rst_total  = 0;  // cycles with core_reset high
    int dn_total   = 0;  // dn_wr pulses
    always @(negedge clk_sys) begin
        if (core_reset && !led) hold_total++;
        if (core_reset) rst_total++;
        if (dn_wr) dn_total++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic download(input int nbytes, input bit last_in_fall,
                            input bit with_button, input bit inject_oor);
        int a;
        int r;
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        ioctl_wr       = 1'b0;
        if (with_button) user_button = 1'b1;
        tick();
        if (with_button) begin
            user_button = 1'b0;
            chk("btn_led", 32'(led), 32'd1);
            chk("btn_rom_ok", 32'(rom_ok), 32'd0);
            chk("btn_hs_enable", 32'(hs_enable), 32'd0);
        end
        if (inject_oor) begin
            ioctl_wr = 1'b1; ioctl_addr = 25'(ROM_SZ);     ioctl_dout = 8'hA5; tick();
            ioctl_wr = 1'b1; ioctl_addr = 25'(ROM_SZ + 5); ioctl_dout = 8'h5A; tick();
        end
        a = 0;
        while (a < nbytes) begin
            r = int'($urandom_range(0, 9));
            if (r < 7) begin
                ioctl_wr   = 1'b1;
                ioctl_addr = 25'(a);
                ioctl_dout = a[7:0];
                a++;
                if (a == nbytes && last_in_fall) ioctl_download = 1'b0;
            end else if (r < 9) begin
                ioctl_wr = 1'b0;
            end else begin
                ioctl_wr   = 1'b1;
                ioctl_dout = 8'($urandom);
                if ($urandom_range(0, 1) == 0)
                    ioctl_addr = 25'(ROM_SZ + int'($urandom_range(0, 200)));
                else
                    ioctl_addr = {8'($urandom_range(1, 255)), 17'($urandom_range(0, ROM_SZ - 1))};
            end
            tick();
        end
        ioctl_wr = 1'b0;
        if (!last_in_fall) begin
            ioctl_download = 1'b0;
            tick();
        end
    endtask

    task automatic dip_write(input logic [24:0] addr, input logic [7:0] data);
        ioctl_index    = 8'd254;
        ioctl_download = 1'b1;
        ioctl_wr       = 1'b1;
        ioctl_addr     = addr;
        ioctl_dout     = data;
        tick();
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        tick();
    endtask

    int snap;
    int dn_snap;

    initial begin
        reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_index = 8'd0;
        ioctl_addr = '0; ioctl_dout = '0; status_reset = 1'b0; user_button = 1'b0;
        service_sw = 1'b0;
        repeat (3) tick();
        chk("reset_core_reset", 32'(core_reset), 32'd1);
        chk("reset_dsw_a", 32'(dsw_a), 32'hFF);
        chk("reset_hs_enable", 32'(hs_enable), 32'd0);
        reset = 1'b0;
        tick();

        // Short download leaves the core in reset with rom_err set.
        dn_snap = dn_total;
        download(1000, 0, 0, 0);
        repeat (1500) tick();
        chk("short_rom_err", 32'(rom_err), 32'd1);
        chk("short_rom_ok", 32'(rom_ok), 32'd0);
        chk("short_core_reset", 32'(core_reset), 32'd1);
        chk("short_dn_count", 32'(dn_total - dn_snap), 32'd1000);

        // DIP writes are accepted while idle in BOOT.
        dip_write(25'd0, 8'h0F);
        chk("boot_dsw_a", 32'(dsw_a), 32'hF0);

        // Full download: exactly HOLD cycles of reset after the load.
        dn_snap = dn_total;
        download(ROM_SZ, 0, 0, 0);
        snap = hold_total;
        repeat (1100) tick();
        chk("full_hold_len", 32'(hold_total - snap), 32'(HOLD));
        chk("full_dn_count", 32'(dn_total - dn_snap), 32'(ROM_SZ));
        chk("full_rom_ok", 32'(rom_ok), 32'd1);
        chk("full_hs_enable", 32'(hs_enable), 32'd1);

        // DIP bytes while running.
        dip_write(25'd0, 8'h3C);
        dip_write(25'd1, 8'h81);
        dip_write(25'd2, 8'h55);
        dip_write(25'h1000000, 8'h00);
        chk("dip_dsw_a", 32'(dsw_a), 32'hC3);
        chk("dip_dsw_b", 32'(dsw_b), 32'h7E);
        chk("dip_core_reset", 32'(core_reset), 32'd0);

        // Service switch held: a single hold.
        snap = rst_total;
        service_sw = 1'b1;
        repeat (5000) tick();
        service_sw = 1'b0;
        tick();
        chk("svc_hold_len", 32'(rst_total - snap), 32'(HOLD));
        chk("svc_hs_enable", 32'(hs_enable), 32'd1);

        // OSD reset during hold cycle 500 restarts the hold.
        snap = rst_total;
        service_sw = 1'b1;
        tick();
        repeat (499) tick();
        status_reset = 1'b1;
        tick();
        status_reset = 1'b0;
        repeat (1600) tick();
        service_sw = 1'b0;
        chk("restart_len", 32'(rst_total - snap), 32'(500 + HOLD));

        // Download start coinciding with a button press; last byte lands on the falling edge.
        download(ROM_SZ, 1, 1, 0);
        snap = hold_total;
        repeat (1100) tick();
        chk("reload_hold_len", 32'(hold_total - snap), 32'(HOLD));
        chk("reload_hs_enable", 32'(hs_enable), 32'd1);
        chk("reload_rom_ok", 32'(rom_ok), 32'd1);

        // Out-of-range writes are neither forwarded nor counted.
        dn_snap = dn_total;
        download(ROM_SZ - 1, 0, 0, 1);
        repeat (200) tick();
        chk("oor_dn_count", 32'(dn_total - dn_snap), 32'(ROM_SZ - 1));
        chk("oor_rom_err", 32'(rom_err), 32'd1);
        chk("oor_core_reset", 32'(core_reset), 32'd1);

        download(ROM_SZ, 1, 0, 0);
        repeat (1100) tick();
        chk("final_hs_enable", 32'(hs_enable), 32'd1);
        chk("final_rom_err", 32'(rom_err), 32'd0);

        // Random reset requests and DIP traffic, checked against the model.
        for (int i = 0; i < 3000; i++) begin
            status_reset = ($urandom_range(0, 299) == 0);
            user_button  = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 99) == 0) service_sw = ~service_sw;
            ioctl_index    = 8'd254;
            ioctl_download = 1'b1;
            ioctl_wr       = ($urandom_range(0, 19) == 0);
            ioctl_addr     = 25'($urandom_range(0, 3));
            ioctl_dout     = 8'($urandom);
            tick();
        end
        status_reset = 1'b0; user_button = 1'b0; service_sw = 1'b0;
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        repeat (1100) tick();
        chk("random_end_hs_enable", 32'(hs_enable), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/xevious_boot_ctrl.md
Name: xevious_boot_ctrl

Overview:
- Sequences core start-up and the `ioctl` download stream for the Xevious core.
- Routes ROM download bytes to the core's `dn_*` port and latches the two DIP bytes.
- Owns the core reset: held during and after ROM load, and on OSD/user/service reset requests.
- Enables the hiscore engine only while the core is running on a complete ROM set.

Parameters:
- ROM_INDEX, 8'd0, `ioctl_index` value for the ROM set.
- DIP_INDEX, 8'd254, `ioctl_index` value for the DIP bytes.
- ROM_SIZE, 17'd69632, bytes required for a complete ROM set.
- HOLD_CYCLES, 1024, core reset stretch after load or reset request (≥2).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- ioctl_download  in  1  HPS transfer active.
- ioctl_wr  in  1  byte strobe, one cycle.
- ioctl_index  in  8  transfer type.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- status_reset  in  1  OSD reset (level).
- user_button  in  1  board reset button (level).
- service_sw  in  1  OSD service-mode switch (level).
- dn_wr  out  1  ROM write strobe to core.
- dn_addr  out  17  ROM write address.
- dn_data  out  8  ROM write data.
- dsw_a  out  8  DIP bank A, active-low (inverted `ioctl_dout`).
- dsw_b  out  8  DIP bank B, active-low.
- core_reset  out  1  reset to core.
- rom_ok  out  1  complete ROM set loaded.
- rom_err  out  1  last ROM download was short.
- hs_enable  out  1  hiscore engine may run.
- led  out  1  high in LOAD.

Behaviour:
- Clock is `clk_sys`; reset is synchronous, active-high. Every output is a register.
- Values on `reset`:
  - State is BOOT.
  - `core_reset` = 1.
  - `dn_wr`, `rom_ok`, `rom_err`, `hs_enable`, `led` = 0.
  - `dn_addr`, `dn_data` = 0.
  - `dsw_a`, `dsw_b` = 8'hFF.
  - Byte counter and hold counter = 0.
  - Edge-detect register of the reset request = current request value, so a level held through reset causes no spurious edge.
- FSM states:
  - BOOT: `core_reset` = 1. Goes to LOAD when `ioctl_download` && `ioctl_index` == ROM_INDEX.
  - LOAD: `core_reset` = 1, `led` = 1. Byte counter cleared on entry. Leaves when `ioctl_download` falls:
    - count ≥ ROM_SIZE → `rom_ok` = 1, `rom_err` = 0, go to HOLD.
    - otherwise → `rom_ok` = 0, `rom_err` = 1, go to BOOT.
  - HOLD: `core_reset` = 1. Hold counter loaded with HOLD_CYCLES-1 on entry, decrements each cycle. At 0 goes to RUN, so `core_reset` is high for exactly HOLD_CYCLES cycles in HOLD.
  - RUN: `core_reset` = 0, `hs_enable` = 1.
- Reset request `rreq` = `status_reset` | `user_button` | rising edge of `service_sw`.
  - RUN + `rreq` → HOLD.
  - HOLD + `rreq` → counter reloaded, HOLD restarts.
  - BOOT/LOAD: `rreq` ignored.
- ROM download start with `ioctl_index` == ROM_INDEX from RUN or HOLD → LOAD. This takes priority over `rreq` in the same cycle. `rom_ok` clears on LOAD entry.
- `hs_enable` = 1 only in RUN. It drops in the same cycle `core_reset` rises.
- ROM write path (latency 1):
  - In LOAD, when `ioctl_wr` && `ioctl_addr` < ROM_SIZE: next cycle `dn_wr` = 1, `dn_addr` = `ioctl_addr[16:0]`, `dn_data` = `ioctl_dout`, byte counter += 1. The counter saturates at ROM_SIZE.
  - Writes at addresses ≥ ROM_SIZE are dropped and not counted.
  - `dn_wr` is never high outside LOAD and is otherwise 0 each cycle.
- DIP path, active in any state:
  - On `ioctl_wr` && `ioctl_index` == DIP_INDEX && `ioctl_addr[24:1]` == 0: addr bit0 = 0 → `dsw_a` <= ~`ioctl_dout`; bit0 = 1 → `dsw_b` <= ~`ioctl_dout`. Visible next cycle.
  - Other DIP addresses are ignored. DIP writes do not affect the FSM.
- Writes with any other `ioctl_index` are ignored.
- `ioctl_download` falling and `ioctl_wr` in the same cycle: the byte is counted before the length check.

Test Plan:
- Reset, then a ROM_SIZE-byte download at index 0 with data = addr[7:0] → each `dn_wr` one cycle after `ioctl_wr` with matching addr/data. `led` = 1 throughout. After download ends: `rom_ok` = 1, `core_reset` high for exactly 1024 cycles, then 0, with `hs_enable` rising the same cycle.
- Download of 1000 bytes at index 0 → `rom_err` = 1, `rom_ok` = 0, state BOOT, `core_reset` remains 1 indefinitely.
- Index 254, writes addr 0 = 8'h3C, addr 1 = 8'h81, addr 2 = 8'h55 → `dsw_a` = 8'hC3, `dsw_b` = 8'h7E, addr 2 has no effect; FSM unchanged in RUN.
- In RUN, `service_sw` held high 5000 cycles → one hold of 1024 cycles, then RUN again with no further reset. Second run with `status_reset` pulsed at hold cycle 500 → total reset length 500 + 1024 cycles.
- In RUN, index-0 download starts in the same cycle `user_button` = 1 → LOAD entered, `rom_ok` = 0, `hs_enable` = 0. A full reload returns to RUN after the hold.
- Index-0 download writes at addr ROM_SIZE and ROM_SIZE+5 → no `dn_wr` pulses, byte count unchanged.
